// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem requests, one-entry ID slot.
// Define IF_PREDICT_EN to let the branch predictor steer the next fetch PC.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic [31:0] pd_pc_o,
    input  logic        pd_taken_i,
    input  logic [31:0] pd_target_i,
    input  logic        pd_failed_i,
    input  logic [31:0] pd_flush_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_pred_taken_o,
    output logic [31:0] id_pred_target_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        kill;
    logic [31:0] fl_pc;
    logic        fl_taken;
    logic [31:0] fl_target;

    logic        slot_valid;
    logic [31:0] slot_pc;
    logic [31:0] slot_inst;
    logic        slot_taken;
    logic [31:0] slot_target;

    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] next_pc;
    logic        req;
    logic        fire;
    logic        load;
    logic        consume;

`ifdef IF_PREDICT_EN
    assign pred_taken  = pd_taken_i;
    assign pred_target = pd_target_i;
`else
    logic unused_pred;
    assign unused_pred = ^{pd_taken_i, pd_target_i};
    assign pred_taken  = 1'b0;
    assign pred_target = '0;
`endif

    assign next_pc = pred_taken ? pred_target : pc + 32'd4;
    // Only request when the slot will be free by the time the response lands.
    assign req     = (state == REQ) && (!slot_valid || id_ready_i);
    assign fire    = req && imem_gnt_i;
    assign load    = (state == WAIT) && imem_rvalid_i && !kill && !pd_failed_i;
    assign consume = slot_valid && id_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            fl_pc     <= '0;
            fl_taken  <= 1'b0;
            fl_target <= '0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (fire) begin
                        fl_pc     <= pc;
                        fl_taken  <= pred_taken;
                        fl_target <= pred_target;
                        pc        <= next_pc;
                        kill      <= pd_failed_i;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        kill  <= 1'b0;
                        state <= REQ;
                    end else if (pd_failed_i) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Redirect wins over any same-cycle sequential or predicted advance.
            if (pd_failed_i) pc <= pd_flush_pc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_valid  <= 1'b0;
            slot_pc     <= '0;
            slot_inst   <= '0;
            slot_taken  <= 1'b0;
            slot_target <= '0;
        end else begin
            if (load) begin
                slot_valid  <= 1'b1;
                slot_pc     <= fl_pc;
                slot_inst   <= imem_rdata_i;
                slot_taken  <= fl_taken;
                slot_target <= fl_target;
            end else if (consume) begin
                slot_valid <= 1'b0;
            end
            if (pd_failed_i) slot_valid <= 1'b0;
        end
    end

    assign pd_pc_o          = pc;
    assign imem_addr_o      = pc;
    assign imem_req_o       = req;
    assign id_valid_o       = slot_valid;
    assign id_pc_o          = slot_pc;
    assign id_inst_o        = slot_inst;
    assign id_pred_taken_o  = slot_taken;
    assign id_pred_target_o = slot_target;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: reference PC/FSM model plus an in-order memory model.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pd_pc;
    logic        pd_taken = 1'b0;
    logic [31:0] pd_target = '0;
    logic        pd_failed = 1'b0;
    logic [31:0] pd_flush_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .pd_pc_o         (pd_pc),
        .pd_taken_i      (pd_taken),
        .pd_target_i     (pd_target),
        .pd_failed_i     (pd_failed),
        .pd_flush_pc_i   (pd_flush_pc),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_gnt_i      (imem_gnt),
        .imem_rvalid_i   (imem_rvalid),
        .imem_rdata_i    (imem_rdata),
        .id_valid_o      (id_valid),
        .id_ready_i      (id_ready),
        .id_pc_o         (id_pc),
        .id_inst_o       (id_inst),
        .id_pred_taken_o (id_pred_taken),
        .id_pred_target_o(id_pred_target)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    ent_t        sb[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [31:0] m_pc = RESET_PC;
    logic        m_idle = 1'b1;
    logic        m_busy = 1'b0;
    logic        m_killed = 1'b0;
    ent_t        m_inflight;
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = '0;
    int unsigned mem_cnt = 0;
    int unsigned mem_lat = 1;
    logic [31:0] hit_pc = 32'h8000_0008;
    logic [31:0] hit_target = 32'h8000_0100;
    logic        rand_pred = 1'b0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit later, update the model.
    task automatic cycle(input logic rdy, input logic gnt, input logic fl, input logic [31:0] fl_pc);
        logic exp_req;
        logic rv;
        ent_t e;
        exp_req     = !m_idle && !m_busy && (sb.size() == 0 || rdy);
        id_ready    = rdy;
        imem_gnt    = gnt;
        pd_failed   = fl;
        pd_flush_pc = fl_pc;
`ifdef IF_PREDICT_EN
        if (exp_req) begin
            pd_taken  = rand_pred ? 1'($urandom_range(0, 1)) : (m_pc == hit_pc);
            pd_target = rand_pred ? {16'h8000, 16'($urandom) & 16'hfffc} : hit_target;
        end else begin
            pd_taken  = 1'($urandom_range(0, 1));
            pd_target = $urandom;
        end
`else
        pd_taken  = 1'b1;
        pd_target = $urandom;
`endif
        if (mem_pend && mem_cnt > 0) mem_cnt--;
        rv          = mem_pend && mem_cnt == 0;
        imem_rvalid = rv;
        imem_rdata  = rv ? inst_of(mem_addr) : '0;
        #1;
        check("req", 32'(imem_req), 32'(exp_req));
        check("valid", 32'(id_valid), 32'(sb.size() != 0));
        check("pd_pc", pd_pc, m_pc);
        if (exp_req) check("addr", imem_addr, m_pc);
        if (sb.size() != 0) begin
            check("id_pc", id_pc, sb[0].pc);
            check("id_inst", id_inst, sb[0].inst);
            check("id_taken", 32'(id_pred_taken), 32'(sb[0].taken));
            check("id_target", id_pred_target, sb[0].target);
            if (rdy) void'(sb.pop_front());
        end
        if (rv) begin
            mem_pend = 1'b0;
            if (!m_killed && !fl) sb.push_back(m_inflight);
            m_busy   = 1'b0;
            m_killed = 1'b0;
        end
        if (exp_req && gnt) begin
            e.pc   = m_pc;
            e.inst = inst_of(m_pc);
`ifdef IF_PREDICT_EN
            e.taken  = pd_taken;
            e.target = pd_target;
`else
            e.taken  = 1'b0;
            e.target = '0;
`endif
            m_inflight = e;
            m_busy     = 1'b1;
            m_killed   = 1'b0;
            mem_pend   = 1'b1;
            mem_addr   = m_pc;
            mem_cnt    = mem_lat;
            m_pc       = e.taken ? e.target : m_pc + 32'd4;
        end
        if (fl) begin
            sb.delete();
            if (m_busy) m_killed = 1'b1;
            m_pc = fl_pc;
        end
        m_idle = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        id_ready    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        pd_failed   = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_pd_pc", pd_pc, RESET_PC);
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_inst", id_inst, 32'd0);
        check("rst_id_taken", 32'(id_pred_taken), 32'd0);
        check("rst_id_target", id_pred_target, 32'd0);
        @(negedge clk);
        @(negedge clk);
        sb.delete();
        m_pc     = RESET_PC;
        m_idle   = 1'b1;
        m_busy   = 1'b0;
        m_killed = 1'b0;
        mem_pend = 1'b0;
        rst_n    = 1'b1;
    endtask

    function automatic logic cond_met(input int mode);
        case (mode)
            0:       return m_busy && mem_pend && mem_cnt == mem_lat;
            1:       return !m_idle && !m_busy;
            default: return sb.size() == 1;
        endcase
    endfunction

    // Bounded advance until the model reaches a phase: 0 just granted, 1 in REQ, 2 slot full.
    task automatic run_until(input int mode);
        for (int i = 0; i < 32; i++) begin
            if (cond_met(mode)) break;
            cycle(1'b1, 1'b1, 1'b0, '0);
        end
        check("run_until_timeout", 32'(cond_met(mode)), 32'd1);
    endtask

    initial begin
        #2;
        do_reset();
        repeat (12) cycle(1'b1, 1'b1, 1'b0, '0);

        mem_lat = 2;
        run_until(0);
        cycle(1'b1, 1'b1, 1'b1, 32'h8000_0040);
        repeat (8) cycle(1'b1, 1'b1, 1'b0, '0);

        mem_lat = 1;
        run_until(0);
        cycle(1'b1, 1'b1, 1'b1, 32'h8000_0200);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);

        run_until(1);
        cycle(1'b1, 1'b1, 1'b1, 32'h8000_0300);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);

        run_until(2);
        repeat (5) cycle(1'b0, 1'b1, 1'b0, '0);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);

        run_until(1);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b1, 32'h8000_0080);
        cycle(1'b1, 1'b0, 1'b0, '0);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);

        rand_pred = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!mem_pend) mem_lat = $urandom_range(1, 3);
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0,
                  {16'h8000, 16'($urandom) & 16'hfffc});
        end
        rand_pred = 1'b0;

        run_until(0);
        do_reset();
        repeat (8) cycle(1'b1, 1'b1, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
